// File: rtl/layer_out_serializer_pkg.sv
// Shared types and defaults for the layer output serializer.
// Activation width follows the neuron ROM width so both sides of the link agree.
`ifndef ROM_bitwidth
`define ROM_bitwidth 16
`endif

package layer_out_serializer_pkg;

  localparam int DEFAULT_NUM_NEURONS = 32;
  localparam int DEFAULT_DATA_WIDTH  = `ROM_bitwidth;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_STREAM  = 2'd2
  } state_e;

endpackage

// File: rtl/layer_out_serializer.sv
// Collects one activation per neuron on its own outvalid pulse, then streams the
// full vector neuron 0 first with valid/ready handshaking to the next layer.
module layer_out_serializer
  import layer_out_serializer_pkg::*;
#(
  parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic                              out_last,
  output logic [IDX_WIDTH-1:0]              out_idx,
  output logic                              busy,
  output logic                              overrun
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  state_e                 state_q, state_d;
  logic [NUM_NEURONS-1:0] flags_q, flags_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0]  buf_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]  buf_d [NUM_NEURONS];

  logic                   xfer, last_xfer, cap_allowed;
  logic [NUM_NEURONS-1:0] flag_base, cap_mask;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    flags_d     = flags_q;
    idx_d       = idx_q;
    overrun_d   = overrun_q;
    flag_base   = flags_q;
    cap_allowed = 1'b0;
    cap_mask    = '0;
    xfer        = out_valid_q & out_ready;
    last_xfer   = xfer & (idx_q == LAST_IDX);

    unique case (state_q)
      S_IDLE:    cap_allowed = 1'b1;
      S_COLLECT: begin
        cap_allowed = 1'b1;
        if (|(in_valid & flags_q)) overrun_d = 1'b1;
      end
      S_STREAM: begin
        if (last_xfer) begin
          // Final word leaves this cycle: the flags are free again, so a new
          // vector arriving now starts collecting instead of being an overrun.
          cap_allowed = 1'b1;
          flag_base   = '0;
        end else begin
          if (|in_valid) overrun_d = 1'b1;
          if (xfer) idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cap_allowed) begin
      cap_mask = in_valid & ~flag_base;
      flags_d  = flag_base | cap_mask;
      idx_d    = '0;
      if (&flags_d)      state_d = S_STREAM;
      else if (|flags_d) state_d = S_COLLECT;
      else               state_d = S_IDLE;
    end

    for (int k = 0; k < NUM_NEURONS; k++) begin
      buf_d[k] = cap_mask[k] ? in_data[k*DATA_WIDTH +: DATA_WIDTH] : buf_q[k];
    end

    // Outputs are registered from the post-capture view so neuron 0 is visible
    // on the first STREAM cycle even if it was the last neuron to report.
    out_valid_d = (state_d == S_STREAM);
    out_data_d  = out_valid_d ? buf_d[idx_d] : '0;
    out_last_d  = out_valid_d && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      flags_q     <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      state_q     <= state_d;
      flags_q     <= flags_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the data buffer has no reset; the capture flags alone qualify its contents.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = idx_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: doc/layer_out_serializer.md
Name: layer_out_serializer

Overview:
- Sits directly downstream of one hidden layer's bank of neuron instances.
- Captures each neuron's activation output on that neuron's own outvalid pulse and holds it until every neuron in the layer has reported.
- Then streams the captured values one per cycle, neuron 0 first, as the myinput/myinputValid stream for the next layer's neurons.
- Absorbs skew between neuron outvalid pulses and decouples layer timing.

Parameters:
- NUM_NEURONS, 32, number of neurons in the upstream layer (≥2).
- DATA_WIDTH, 16, width of each activation value; equals `ROM_bitwidth and the downstream `dataWidth.
- IDX_WIDTH, $clog2(NUM_NEURONS), width of the stream index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- in_valid  in  NUM_NEURONS  per-neuron outvalid; bit k is neuron k.
- in_data  in  NUM_NEURONS*DATA_WIDTH  flattened neuron outputs; neuron k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_ready  in  1  downstream may accept a word this cycle.
- out_data  out  DATA_WIDTH  streamed activation (registered).
- out_valid  out  1  out_data valid (registered).
- out_last  out  1  high with out_valid on the word of neuron NUM_NEURONS-1.
- out_idx  out  IDX_WIDTH  neuron index of the current out_data.
- busy  out  1  high in COLLECT or STREAM.
- overrun  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst=0, async): state=IDLE, capture flags=0, index=0, out_data=0, out_valid=0, out_last=0, out_idx=0, busy=0, overrun=0. Buffer contents are don't-care.
- Storage: buffer of NUM_NEURONS×DATA_WIDTH registers plus NUM_NEURONS capture flags.
- Capture: in IDLE or COLLECT, for each k with in_valid[k]=1 and flag[k]=0:
  - buf[k] <= in_data slice k; flag[k] <= 1.
  - Multiple bits may be set in the same cycle; all are captured.
- FSM IDLE:
  - Any in_valid bit set -> capture, go COLLECT.
  - If that single cycle sets all flags, go directly to STREAM.
- FSM COLLECT:
  - Capture each cycle.
  - When (flags | newly captured) is all ones, next state STREAM with index=0.
- FSM STREAM:
  - out_valid=1, out_data=buf[index], out_idx=index, out_last=(index==NUM_NEURONS-1).
  - Outputs are registered and present from the first STREAM cycle.
  - A word transfers when out_valid & out_ready.
  - On transfer with index<NUM_NEURONS-1: index+1, outputs update next cycle.
  - On transfer of the last word: flags cleared, index=0, outputs to 0 next cycle, state=IDLE.
  - out_ready=0 holds all outputs stable; there is no timeout.
- Latency:
  - Neuron 0 appears on out_data 1 cycle after the cycle in which the final flag is captured.
  - With out_ready held high, NUM_NEURONS consecutive words follow.
- Overrun (overrun<=1, offending data dropped, FSM unaffected):
  - in_valid[k]=1 while flag[k]=1 in COLLECT.
  - Any in_valid bit set during STREAM.
  - Exception: in the final STREAM transfer cycle, new in_valid bits are not overrun. They are captured, and the FSM goes to COLLECT (or STREAM if all bits are set) instead of IDLE. This supports back-to-back vectors.
- busy = (state != IDLE).
- Data is passed through bit-exact: no arithmetic, no sign handling.
- Reset mid-COLLECT or mid-STREAM: immediate return to the reset values above; the partial vector is discarded.

Decomposition:
- Shared package/include holds:
  - state encoding constants S_IDLE=2'd0, S_COLLECT=2'd1, S_STREAM=2'd2.
  - DATA_WIDTH default tied to `ROM_bitwidth.
- No sub-module required. The capture buffer with flags may optionally be a sub-module layer_capture_buf (write-per-bit, read-by-index).

Test Plan (NUM_NEURONS=4, DATA_WIDTH=16):
1. Simultaneous capture: reset, then in_valid=4'b1111 with data {0x0004,0x0003,0x0002,0x0001} (neuron 3..0) for one cycle, out_ready=1 -> next cycle out_valid=1 and out_data sequence 0x0001,0x0002,0x0003,0x0004 on 4 consecutive cycles; out_idx 0..3; out_last only on 0x0004; then out_valid=0, busy=0.
2. Skewed capture: in_valid bits 2,0,3,1 pulsed on cycles 0,2,5,9 (values 0xAAAA,0x1111,0xBBBB,0x2222) -> busy=1 from cycle 1; out_valid rises on cycle 10; stream is 0x1111,0x2222,0xAAAA,0xBBBB.
3. Backpressure: out_ready toggles 1,0,0,1,1,0,1 during STREAM -> each word held stable while out_ready=0; exactly 4 transfers, no duplicates or skips.
4. Overrun: bit 1 pulsed twice during COLLECT (values 0x0005 then 0x0009); then a bit pulsed mid-STREAM -> overrun=1 stays high; streamed word 1 is 0x0005; stream is unaffected.
5. Back-to-back: in the last-word transfer cycle, in_valid=4'b1111 with new data -> no overrun; new 4-word stream starts 1 cycle after the old one ends.
6. Async reset: drive rst=0 mid-STREAM between clock edges -> out_valid, busy and overrun are 0 before the next edge; after release, a fresh 4'b1111 vector streams correctly.
